tap_pattern_recorder: RTL and testbench

//  Live-record path for the drum sequencer. The step sequencer reads the 8-step

---
 rtl/tap_pattern_recorder.sv | 186 ++++++++++++++++++
 tb/tb_tap_pattern_recorder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tap_pattern_recorder.sv
// rtl/tap_pattern_recorder.sv - debounced tap keys quantized to the step grid, recorded for one bar and committed
module tap_pattern_recorder #(
    parameter int NUM_STEPS       = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PERIOD_W        = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_tick,
    input  logic [2:0]           timing,
    input  logic                 arm,
    input  logic                 clear,
    input  logic [3:0]           tap_n,
    output logic [NUM_STEPS-1:0] ins1,
    output logic [NUM_STEPS-1:0] ins2,
    output logic [NUM_STEPS-1:0] ins3,
    output logic [NUM_STEPS-1:0] ins4,
    output logic                 pat_valid,
    output logic [1:0]           rec_state
);

    localparam int              NUM_KEYS  = 4;
    localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      LAST_STEP = 3'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COUNT_IN = 2'd1,
        S_RECORD   = 2'd2,
        S_COMMIT   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] db_level;
    logic [NUM_KEYS-1:0] press;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];

    logic [PERIOD_W-1:0] cyc_cnt;
    logic [PERIOD_W-1:0] period_reg;
    logic [2:0]          cur_step;
    logic [2:0]          q_step;
    logic [NUM_STEPS-1:0] q_mask;

    logic [NUM_STEPS-1:0] shadow    [NUM_KEYS];
    logic [NUM_STEPS-1:0] committed [NUM_KEYS];

    logic bar_start;
    logic do_clear;
    logic do_load;
    logic do_record;
    logic do_commit;

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '1;
            sync2    <= '1;
            db_level <= '1;
            press    <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync1 <= tap_n;
            sync2 <= sync1;
            for (int k = 0; k < NUM_KEYS; k++) begin
                press[k] <= 1'b0;
                if (sync2[k] == db_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_cnt[k]   <= '0;
                    db_level[k] <= sync2[k];
                    press[k]    <= ~sync2[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt    <= '0;
            period_reg <= '0;
            cur_step   <= '0;
        end else if (step_tick) begin
            cyc_cnt    <= '0;
            period_reg <= cyc_cnt + PERIOD_W'(1);
            cur_step   <= timing;
        end else if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + PERIOD_W'(1);
        end
    end

    // A press in the second half of a step belongs to the following step.
    always_comb begin
        q_step = cur_step;
        if (step_tick) begin
            q_step = timing;
        end else if ((period_reg != '0) && (cyc_cnt >= (period_reg >> 1))) begin
            q_step = (cur_step == LAST_STEP) ? 3'd0 : cur_step + 3'd1;
        end
        q_mask         = '0;
        q_mask[q_step] = 1'b1;
    end

    assign bar_start = step_tick && (timing == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_clear  = 1'b0;
        do_load   = 1'b0;
        do_record = 1'b0;
        do_commit = 1'b0;
        pat_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    do_clear = 1'b1;
                end else if (arm) begin
                    state_nxt = S_COUNT_IN;
                end
            end
            S_COUNT_IN: begin
                if (bar_start) begin
                    do_load   = 1'b1;
                    state_nxt = S_RECORD;
                end
            end
            S_RECORD: begin
                do_record = 1'b1;
                if (bar_start) begin
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                do_commit = 1'b1;
                pat_valid = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shadows start from the committed patterns so a new pass overdubs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                shadow[k]    <= '0;
                committed[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (do_clear) begin
                    committed[k] <= '0;
                end else if (do_commit) begin
                    committed[k] <= shadow[k];
                end
                if (do_load) begin
                    shadow[k] <= committed[k];
                end else if (do_record && press[k]) begin
                    shadow[k] <= shadow[k] | q_mask;
                end
            end
        end
    end

    assign ins1      = committed[0];
    assign ins2      = committed[1];
    assign ins3      = committed[2];
    assign ins4      = committed[3];
    assign rec_state = state;

endmodule

// File: tb/tb_tap_pattern_recorder.sv
// tb/tb_tap_pattern_recorder.sv - scoreboard bench for tap_pattern_recorder
module tb_tap_pattern_recorder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_tick = 1'b0;
    logic [2:0] timing = 3'd0;
    logic       arm = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] tap_n = 4'hf;
    logic [7:0] ins1, ins2, ins3, ins4;
    logic       pat_valid;
    logic [1:0] rec_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [31:0] exp_q[$];

    tap_pattern_recorder #(
        .NUM_STEPS(8),
        .DEBOUNCE_CYCLES(4),
        .PERIOD_W(26)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_tick(step_tick),
        .timing(timing),
        .arm(arm),
        .clear(clear),
        .tap_n(tap_n),
        .ins1(ins1),
        .ins2(ins2),
        .ins3(ins3),
        .ins4(ins4),
        .pat_valid(pat_valid),
        .rec_state(rec_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Step grid: a tick every 100 clocks, timing cycling 0..7.
    initial begin : tick_gen
        int phase;
        int step;
        phase = 50;
        step  = 7;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 100;
            if (phase == 0) begin
                step      = (step + 1) % 8;
                timing    = 3'(step);
                step_tick = 1'b1;
            end else begin
                step_tick = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (pat_valid === 1'b1) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pat_valid: got pulse, expected none");
                end else begin
                    e = exp_q.pop_front();
                    @(negedge clk);
                    check("commit_patterns", {ins1, ins2, ins3, ins4}, e);
                end
            end
        end
    end

    task automatic wait_tick(input int s);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(step_tick && timing == 3'(s)) && n < 2000);
        check("tick_wait", {31'd0, step_tick && timing == 3'(s)}, 32'd1);
    endtask

    task automatic open_bar();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("state_count_in", rec_state, 32'd1);
        wait_tick(0);
        @(negedge clk);
        check("state_record", rec_state, 32'd2);
    endtask

    task automatic close_bar(input logic [31:0] exp);
        exp_q.push_back(exp);
        wait_tick(0);
        @(negedge clk);
        check("pat_valid_after_tick", pat_valid, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("state_idle_after_commit", rec_state, 32'd0);
    endtask

    task automatic press(input int k, input int delay, input int hold);
        repeat (delay) @(negedge clk);
        tap_n[k] = 1'b0;
        repeat (hold) @(negedge clk);
        tap_n[k] = 1'b1;
    endtask

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check("reset_state", rec_state, 32'd0);
        check("reset_ins1", ins1, 32'd0);
        check("reset_ins2", ins2, 32'd0);
        check("reset_ins3", ins3, 32'd0);
        check("reset_ins4", ins4, 32'd0);
        check("reset_pat_valid", pat_valid, 32'd0);

        // Empty bar
        open_bar();
        close_bar(32'h00_00_00_00);

        // Early/late taps in step 2, late tap in step 7 wraps to bit 0
        open_bar();
        wait_tick(2);
        press(0, 20, 20);
        press(1, 30, 20);
        wait_tick(7);
        press(3, 80, 15);
        close_bar(32'h04_08_00_01);

        // Glitches shorter than the debounce window, then one long hold
        open_bar();
        wait_tick(3);
        repeat (5) @(negedge clk);
        repeat (2) begin
            tap_n[2] = 1'b0;
            repeat (3) @(negedge clk);
            tap_n[2] = 1'b1;
            repeat (3) @(negedge clk);
        end
        tap_n[2] = 1'b0;
        repeat (300) @(negedge clk);
        tap_n[2] = 1'b1;
        close_bar(32'h04_08_08_01);

        // Overdub; clear during RECORD must be ignored
        open_bar();
        wait_tick(2);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_tick(6);
        press(0, 10, 20);
        close_bar(32'h44_08_08_01);

        // arm and clear together: clear wins
        @(negedge clk);
        arm   = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        clear = 1'b0;
        check("arm_clear_state", rec_state, 32'd0);
        check("clear_patterns", {ins1, ins2, ins3, ins4}, 32'd0);

        open_bar();
        wait_tick(1);
        press(3, 10, 20);
        close_bar(32'h00_00_00_02);

        // Reset mid-RECORD
        open_bar();
        wait_tick(4);
        press(0, 10, 20);
        wait_tick(6);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_state", rec_state, 32'd0);
        check("abort_patterns", {ins1, ins2, ins3, ins4}, 32'd0);
        repeat (1000) @(negedge clk);

        check("pat_valid_count", pulses, 32'd5);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
